// File: rtl/pol2rec_pkg.sv
// ============================================================================
// Module : pol2rec_pkg
// Brief  : Shared widths, angle constants, FSM state type and the output
//          saturation helper for the polar-to-rectangular CORDIC.
//          Optional build macro: POL2REC_GAIN_COMP_EN (adds the SCALE state).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pol2rec_pkg;

  localparam int OUT_W  = 32;      // 16Q16 modulus / result width
  localparam int ANG_W  = 19;      // 9Q10 angle width
  localparam int DP_W   = 36;      // 16Q16 datapath plus 4 guard bits
  localparam int ITER_N = 16;      // CORDIC micro-rotations
  localparam int CNT_W  = 4;       // iteration counter width
  localparam int ROM_W  = 16;      // atan table word width

  localparam int DEG90  = 92160;   // 90.0 degrees in 9Q10
  localparam int DEG180 = 184320;  // 180.0 degrees in 9Q10
  localparam int K_Q16  = 39797;   // 1/CORDIC gain, Q0.16

  // Largest magnitude the 32-bit outputs may carry (symmetric clamp).
  localparam logic signed [DP_W-1:0] SAT_POS = DP_W'(2147483647);
  localparam logic signed [DP_W-1:0] SAT_NEG = -SAT_POS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
`ifdef POL2REC_GAIN_COMP_EN
    SCALE = 2'd2,
`endif
    OUT   = 2'd3
  } state_t;

  // Clamp a datapath value into the symmetric 32-bit output range.
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [DP_W-1:0] v);
    logic signed [DP_W-1:0] c;
    if (v > SAT_POS) begin
      c = SAT_POS;
    end else if (v < SAT_NEG) begin
      c = SAT_NEG;
    end else begin
      c = v;
    end
    return OUT_W'(c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pol2rec_atan_rom.sv
// ============================================================================
// Module : pol2rec_atan_rom
// Brief  : Combinational arctangent table, round(atan(2^-i)*1024) degrees
//          in 9Q10, addressed by the CORDIC iteration counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pol2rec_atan_rom
  import pol2rec_pkg::*;
(
  input  logic [CNT_W-1:0] addr,
  output logic [ROM_W-1:0] atan
);

  // Table lookup; every address is populated so no default value is needed.
  always_comb begin
    atan = '0;
    case (addr)
      4'd0:  atan = 16'd46080;
      4'd1:  atan = 16'd27203;
      4'd2:  atan = 16'd14373;
      4'd3:  atan = 16'd7296;
      4'd4:  atan = 16'd3662;
      4'd5:  atan = 16'd1833;
      4'd6:  atan = 16'd917;
      4'd7:  atan = 16'd458;
      4'd8:  atan = 16'd229;
      4'd9:  atan = 16'd115;
      4'd10: atan = 16'd57;
      4'd11: atan = 16'd29;
      4'd12: atan = 16'd14;
      4'd13: atan = 16'd7;
      4'd14: atan = 16'd4;
      4'd15: atan = 16'd2;
      default: atan = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pol2rec.sv
// ============================================================================
// Module : pol2rec
// Brief  : Iterative polar-to-rectangular converter (rotation-mode CORDIC).
//          x = mod*cos(angle), y = mod*sin(angle), 16Q16 outputs.
//          Optional build macro: POL2REC_GAIN_COMP_EN -- when defined, a SCALE
//          step removes the CORDIC gain; otherwise outputs carry ~1.64676.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pol2rec
  import pol2rec_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    start,
  input  logic signed [OUT_W-1:0] mod,
  input  logic signed [ANG_W-1:0] angle,
  output logic signed [OUT_W-1:0] x,
  output logic signed [OUT_W-1:0] y,
  output logic                    busy,
  output logic                    done,
  output logic                    range_err
);

  localparam logic signed [ANG_W-1:0] ANG_P90  = ANG_W'(DEG90);
  localparam logic signed [ANG_W-1:0] ANG_N90  = ANG_W'(-DEG90);
  localparam logic signed [ANG_W-1:0] ANG_P180 = ANG_W'(DEG180);
  localparam logic signed [ANG_W-1:0] ANG_N180 = ANG_W'(-DEG180);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(ITER_N - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic signed [DP_W-1:0]  xr;
  logic signed [DP_W-1:0]  yr;
  logic signed [ANG_W-1:0] zr;
  logic                    err_r;

  logic [ROM_W-1:0]        atan_q;
  logic signed [ANG_W-1:0] atan_ext;

  logic signed [DP_W-1:0]  mod_ext;
  logic signed [DP_W-1:0]  x_init;
  logic signed [ANG_W-1:0] z_init;
  logic                    ang_bad;

  logic signed [DP_W-1:0]  x_sh;
  logic signed [DP_W-1:0]  y_sh;
  logic signed [DP_W-1:0]  x_it;
  logic signed [DP_W-1:0]  y_it;
  logic signed [ANG_W-1:0] z_it;

  pol2rec_atan_rom u_atan_rom (
    .addr (cnt),
    .atan (atan_q)
  );

  // Fold the operand into the +-90 degree convergence range and flag bad angles.
  always_comb begin
    mod_ext = DP_W'(mod);
    x_init  = mod_ext;
    z_init  = angle;
    ang_bad = (angle > ANG_P180) || (angle < ANG_N180);
    if (angle > ANG_P90) begin
      x_init = -mod_ext;
      z_init = angle - ANG_P180;
    end else if (angle < ANG_N90) begin
      x_init = -mod_ext;
      z_init = angle + ANG_P180;
    end
  end

  // One micro-rotation: direction chosen by the sign of the residual angle.
  always_comb begin
    atan_ext = {{(ANG_W - ROM_W){1'b0}}, atan_q};
    x_sh     = xr >>> cnt;
    y_sh     = yr >>> cnt;
    if (!zr[ANG_W-1]) begin
      x_it = xr - y_sh;
      y_it = yr + x_sh;
      z_it = zr - atan_ext;
    end else begin
      x_it = xr + y_sh;
      y_it = yr - x_sh;
      z_it = zr + atan_ext;
    end
  end

`ifdef POL2REC_GAIN_COMP_EN
  localparam int PROD_W = DP_W + 18;
  localparam logic signed [PROD_W-1:0] K_EXT    = PROD_W'(K_Q16);
  localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(32768);

  logic signed [PROD_W-1:0] x_prod;
  logic signed [PROD_W-1:0] y_prod;
  logic signed [DP_W-1:0]   x_scaled;
  logic signed [DP_W-1:0]   y_scaled;

  // Gain compensation: multiply by K in Q0.16 and round to nearest.
  always_comb begin
    x_prod   = PROD_W'(xr) * K_EXT;
    y_prod   = PROD_W'(yr) * K_EXT;
    x_scaled = DP_W'((x_prod + RND_HALF) >>> 16);
    y_scaled = DP_W'((y_prod + RND_HALF) >>> 16);
  end
`endif

  // Control FSM and datapath registers; enable low freezes everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      xr        <= '0;
      yr        <= '0;
      zr        <= '0;
      err_r     <= 1'b0;
      x         <= '0;
      y         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      range_err <= 1'b0;
    end else if (enable) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xr    <= x_init;
            yr    <= '0;
            zr    <= z_init;
            err_r <= ang_bad;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ITER;
          end
        end
        ITER: begin
          xr  <= x_it;
          yr  <= y_it;
          zr  <= z_it;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
`ifdef POL2REC_GAIN_COMP_EN
            state <= SCALE;
`else
            state <= OUT;
`endif
          end
        end
`ifdef POL2REC_GAIN_COMP_EN
        SCALE: begin
          xr    <= x_scaled;
          yr    <= y_scaled;
          state <= OUT;
        end
`endif
        OUT: begin
          // An out-of-range angle still takes the full latency but reports zero.
          x         <= err_r ? '0 : sat_out(xr);
          y         <= err_r ? '0 : sat_out(yr);
          range_err <= err_r;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/pol2rec.md
POL2REC -- requirements
Module: pol2rec

Interface
REQ-001 The block SHALL have these ports: clock  in  1  sole clock, all registers on rising edge.
REQ-002 reset  in  1  asynchronous, active-low; SHALL clear all state when low.
REQ-003 enable  in  1  high = advance; low = every register holds its value.
REQ-004 start  in  1  one-cycle pulse that loads operands; SHALL be honoured only when enable=1 and the FSM is IDLE.
REQ-005 mod  in  32  signed modulus, 16Q16.
REQ-006 angle  in  19  signed angle in degrees, 9Q10; legal range -184320..+184320 (±180.0°).
REQ-007 x  out  32  signed X = mod*cos(angle), 16Q16, registered.
REQ-008 y  out  32  signed Y = mod*sin(angle), 16Q16, registered.
REQ-009 busy  out  1  high from the cycle after an accepted start until done.
REQ-010 done  out  1  one-cycle pulse when x/y are updated.
REQ-011 range_err  out  1  registered with done; high if the captured angle was outside the legal range.

Function
REQ-012 The FSM SHALL have states IDLE, ITER, SCALE, OUT; transitions occur only when enable=1.
REQ-013 IDLE->ITER on an accepted start: capture mod/angle, clear the iteration counter to 0, assert busy.
REQ-014 Quadrant pre-rotation at load: if angle>92160 then x0=-mod and z0=angle-184320; if angle<-92160 then x0=-mod and z0=angle+184320; otherwise x0=mod and z0=angle; y0=0 in all cases.
REQ-015 ITER SHALL run 16 iterations, i=0..15, one per enabled cycle.
REQ-016 Iteration rule: if z>=0 then x'=x-(y>>>i), y'=y+(x>>>i), z'=z-atan_i; otherwise apply the opposite signs.
REQ-017 atan_i SHALL be round(atan(2^-i)*1024), degrees in 9Q10, as a 16-bit unsigned constant zero-extended to 19 bits (atan_0=46080).
REQ-018 The internal x/y datapath SHALL be 36-bit signed (16Q16 plus 4 guard bits); shifts SHALL be arithmetic.
REQ-019 After i=15, the FSM SHALL go to SCALE if gain compensation is compiled in, else to OUT.
REQ-020 OUT SHALL saturate x/y to ±(2^31-1), register them, pulse done for one cycle, drop busy, and return to IDLE.
REQ-021 On range_err the block SHALL still run the full latency, and x and y SHALL be 0.
REQ-022 Latency: with start accepted at edge E0, done SHALL be high after E17 without compensation and after E18 with it, plus one cycle for every cycle enable=0.
REQ-023 start while busy SHALL be ignored; x/y SHALL hold between done pulses.

Reset
REQ-024 When reset is low, x, y, busy, done, range_err, the counter and all datapath registers SHALL be 0 and the FSM SHALL be IDLE, including mid-operation.
REQ-025 After reset is released, the first accepted start SHALL behave as from power-up.

Configuration
REQ-026 Macro POL2REC_GAIN_COMP_EN defined: SCALE multiplies x and y by K=39797 (0.60725, Q0.16), rounds to nearest, and adds one cycle of latency.
REQ-027 Macro POL2REC_GAIN_COMP_EN undefined: there is no SCALE state, and the outputs carry the CORDIC gain of about 1.64676, saturated per REQ-020.

Structure
REQ-028 Package pol2rec_pkg SHALL hold: the width constants (32, 19, 36), ITER_N=16, DEG90=92160, DEG180=184320, K_Q16=39797, and the FSM state enum.
REQ-029 The atan table SHALL be a separate combinational sub-module, pol2rec_atan_rom, addressed by the 4-bit counter with 16-bit output.

Verification
REQ-030 Comp on, mod=65536, angle=0 -> x=65536±8, y=0±8, done after E18.
REQ-031 Comp on, mod=65536, angle=92160 -> x=0±8, y=65536±8; angle=-46080 -> x=46341±8, y=-46341±8.
REQ-032 Comp on, mod=65536, angle=184320 -> x=-65536±8, y=0±8, range_err=0; angle=204800 -> x=y=0, range_err=1.
REQ-033 Comp off, mod=65536, angle=0 -> x=107920±16, done after E17.
REQ-034 enable low for 5 cycles mid-ITER -> done delayed exactly 5 cycles, result identical to REQ-030.
REQ-035 reset low during ITER i=7 -> all outputs 0, IDLE; a restart then reproduces REQ-030; a start pulsed while busy -> no effect.
